// File: rtl/apb_arb_pkg.sv
// Shared types for apb_req_arbiter: FSM states, the latched transfer and a grant-width helper.
// Optional feature macro used by the top: APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;
  localparam int XFER_ADDR_W = 16;
  localparam int XFER_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  // Field widths are the bus widths of apb_req_arbiter (its width parameters default to these).
  typedef struct packed {
    logic                   write;
    logic [XFER_ADDR_W-1:0] addr;
    logic [XFER_DATA_W-1:0] wdata;
  } apb_xfer_t;

  // GNT_W helper: $clog2(num_req), never narrower than one bit.
  function automatic int gnt_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked request after last_grant, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GNT_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [GNT_W-1:0]   last_grant,
  output logic               valid,
  output logic [GNT_W-1:0]   idx
);
  // Walk distances from farthest to nearest so the nearest eligible requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int d = NUM_REQ; d >= 1; d--) begin
      if (req[(int'(last_grant) + d) % NUM_REQ] && !mask[(int'(last_grant) + d) % NUM_REQ]) begin
        valid = 1'b1;
        idx   = GNT_W'((int'(last_grant) + d) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// APB master sharing one target between NUM_REQ requesters with round-robin grants.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles with o_err.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = XFER_ADDR_W,
  parameter int APB_DATA_WIDTH = XFER_DATA_W,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [NUM_REQ-1:0]                i_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]                o_done,
  output logic                              o_err,
  output logic [APB_DATA_WIDTH-1:0]         o_rdata,
  output logic                              o_psel,
  output logic                              o_penable,
  output logic                              o_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]         o_paddr,
  output logic [APB_DATA_WIDTH-1:0]         o_pwdata,
  input  logic                              i_pready,
  input  logic [APB_DATA_WIDTH-1:0]         i_prdata,
  output apb_arb_state_e                    o_state
);
  // Handshake: i_req[k] is held with its write/addr/wdata until o_done[k]; o_done is a
  // one-cycle pulse, and the served requester is masked in that cycle.
  localparam int GNT_W = gnt_w(NUM_REQ);

  apb_arb_state_e     state;
  apb_xfer_t          xfer;
  apb_xfer_t          next_xfer;
  logic [GNT_W-1:0]   gnt;
  logic [GNT_W-1:0]   last_grant;
  logic [GNT_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [NUM_REQ-1:0] gnt_onehot;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GNT_W(GNT_W)) u_rr (
    .req        (i_req),
    .mask       (o_done),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .idx        (arb_idx)
  );

  always_comb begin
    next_xfer       = '0;
    next_xfer.write = i_write[arb_idx];
    next_xfer.addr  = i_addr[int'(arb_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    next_xfer.wdata = i_wdata[int'(arb_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  end

  assign gnt_onehot = NUM_REQ'(1) << gnt;
  assign o_pwrite   = xfer.write;
  assign o_paddr    = xfer.addr;
  assign o_pwdata   = xfer.wdata;
  assign o_state    = state;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      xfer       <= '0;
      gnt        <= '0;
      last_grant <= GNT_W'(NUM_REQ-1);
      o_psel     <= 1'b0;
      o_penable  <= 1'b0;
      o_done     <= '0;
      o_rdata    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      o_err      <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      o_done <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      o_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (arb_valid) begin
            state  <= SETUP;
            gnt    <= arb_idx;
            xfer   <= next_xfer;
            o_psel <= 1'b1;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          o_penable <= 1'b1;
        end
        ACCESS: begin
          if (i_pready) begin
            state      <= IDLE;
            o_psel     <= 1'b0;
            o_penable  <= 1'b0;
            o_done     <= gnt_onehot;
            last_grant <= gnt;
            o_rdata    <= xfer.write ? '0 : i_prdata;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // Abort on the TIMEOUT_CYCLES-th consecutive wait cycle.
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            state      <= IDLE;
            o_psel     <= 1'b0;
            o_penable  <= 1'b0;
            o_done     <= gnt_onehot;
            last_grant <= gnt;
            o_rdata    <= '0;
            o_err      <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          o_psel    <= 1'b0;
          o_penable <= 1'b0;
        end
      endcase
    end
  end
endmodule
